// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// grant FSM state encoding, access size codes, default tuning values
// and a helper for sizing small counters.
package arb_pkg;

   // Grant FSM states; the encoding is fixed so waveforms read the same
   // across builds.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_IF  = 2'd1,
      WAIT_MEM = 2'd2
   } arbState_t;

   // Access size codes as presented on mem_size / ram_size.
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Default tuning: fetch may lose this many arbitrations in a row,
   // and a memory access is abandoned after this many wait cycles.
   localparam int DEF_MAX_STARVE = 3;
   localparam int DEF_TIMEOUT    = 16;
   localparam int DEF_AW         = 32;

   // Bits needed to hold values 0..maxVal (at least one bit).
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Grant and conflict statistics for the memory port arbiter.
// Only instantiated when ARB_PERF_CNT_EN is defined. Counters are free
// running, wrap at 2^32 and advance on the same edge as the grant.
module arb_perf_counters (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_grantIf,
   input  logic        i_grantMem,
   input  logic        i_conflict,
   output logic [31:0] o_ifGrants,
   output logic [31:0] o_memGrants,
   output logic [31:0] o_conflicts
);

   logic [31:0] r_ifGrants;
   logic [31:0] r_memGrants;
   logic [31:0] r_conflicts;

   // Count each grant and each contested arbitration cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ifGrants  <= '0;
         r_memGrants <= '0;
         r_conflicts <= '0;
      end else begin
         if (i_grantIf) begin
            r_ifGrants <= r_ifGrants + 32'd1;
         end
         if (i_grantMem) begin
            r_memGrants <= r_memGrants + 32'd1;
         end
         if (i_conflict) begin
            r_conflicts <= r_conflicts + 32'd1;
         end
      end
   end

   assign o_ifGrants  = r_ifGrants;
   assign o_memGrants = r_memGrants;
   assign o_conflicts = r_conflicts;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (IF) port and the
// load/store (MEM) port of the pipeline. One access is outstanding at a
// time; the memory acks each access with ram_valid, and an access that is
// never acked is abandoned after TIMEOUT wait cycles, raising the sticky
// bus_err. MEM normally wins a collision, but after MAX_STARVE consecutive
// losses IF is forced through.
// Optional build macro: ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_STARVE = DEF_MAX_STARVE,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int AW         = DEF_AW
) (
   input  logic          clk,
   input  logic          reset_n,
   // fetch port
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [31:0]   if_rdata,
   output logic          if_ready,
   // load/store port
   input  logic          mem_req,
   input  logic          mem_we,
   input  logic [1:0]    mem_size,
   input  logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_wdata,
   output logic [31:0]   mem_rdata,
   output logic          mem_ready,
   // memory side
   output logic          ram_en,
   output logic          ram_we,
   output logic [1:0]    ram_size,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata,
   input  logic          ram_valid,
   // pipeline hazard lines and status
   output logic          stall_if,
   output logic          stall_mem,
   output logic          bus_err
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]   perf_if_grants,
   output logic [31:0]   perf_mem_grants,
   output logic [31:0]   perf_conflicts
`endif
);

   localparam int SW = cntWidth(MAX_STARVE);
   localparam int TW = cntWidth(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   arbState_t      r_state;
   logic [SW-1:0]  r_starveCnt;
   logic [TW-1:0]  r_timer;
   logic           r_ramEn;
   logic           r_ramWe;
   logic [1:0]     r_ramSize;
   logic [AW-1:0]  r_ramAddr;
   logic [31:0]    r_ramWdata;
   logic [31:0]    r_ifRdata;
   logic           r_ifReady;
   logic [31:0]    r_memRdata;
   logic           r_memReady;
   logic           r_busErr;

   logic           w_ifElig;
   logic           w_memElig;
   logic           w_isIdle;
   logic           w_grantMem;
   logic           w_grantIf;
   logic           w_timeout;
   logic [31:0]    w_respData;

   // A port whose ready pulse is on this cycle is still dropping its
   // request, so it sits out arbitration to avoid a duplicate grant.
   // MEM wins a collision until IF has lost MAX_STARVE times in a row.
   always_comb begin
      w_ifElig   = if_req & ~r_ifReady;
      w_memElig  = mem_req & ~r_memReady;
      w_isIdle   = (r_state == IDLE);
      w_grantMem = w_isIdle & w_memElig & ((r_starveCnt < STARVE_MAX) | ~w_ifElig);
      w_grantIf  = w_isIdle & w_ifElig & ~w_grantMem;
      w_timeout  = (r_timer == TIMER_LAST);
      w_respData = r_ramWe ? 32'd0 : ram_rdata;
   end

   // Grant FSM: issue one access, wait for its ack or the timeout, then
   // return to arbitration. Every output it drives is registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_starveCnt <= '0;
         r_timer     <= '0;
         r_ramEn     <= 1'b0;
         r_ramWe     <= 1'b0;
         r_ramSize   <= 2'd0;
         r_ramAddr   <= '0;
         r_ramWdata  <= '0;
         r_ifRdata   <= '0;
         r_ifReady   <= 1'b0;
         r_memRdata  <= '0;
         r_memReady  <= 1'b0;
         r_busErr    <= 1'b0;
      end else begin
         r_ramEn    <= 1'b0;
         r_ifReady  <= 1'b0;
         r_memReady <= 1'b0;
         case (r_state)
            IDLE: begin
               r_timer <= '0;
               if (w_grantMem) begin
                  r_ramEn    <= 1'b1;
                  r_ramWe    <= mem_we;
                  r_ramSize  <= mem_size;
                  r_ramAddr  <= mem_addr;
                  r_ramWdata <= mem_wdata;
                  r_state    <= WAIT_MEM;
                  // The grant condition keeps the count below its cap
                  // whenever IF was also asking, so this never overflows.
                  if (w_ifElig) begin
                     r_starveCnt <= r_starveCnt + SW'(1);
                  end else begin
                     r_starveCnt <= '0;
                  end
               end else if (w_grantIf) begin
                  r_ramEn     <= 1'b1;
                  r_ramWe     <= 1'b0;
                  r_ramSize   <= SZ_WORD;
                  r_ramAddr   <= if_addr;
                  r_ramWdata  <= '0;
                  r_state     <= WAIT_IF;
                  r_starveCnt <= '0;
               end
            end
            WAIT_IF, WAIT_MEM: begin
               if (ram_valid || w_timeout) begin
                  if (r_state == WAIT_IF) begin
                     r_ifRdata <= ram_valid ? w_respData : 32'd0;
                     r_ifReady <= 1'b1;
                  end else begin
                     r_memRdata <= ram_valid ? w_respData : 32'd0;
                     r_memReady <= 1'b1;
                  end
                  if (!ram_valid) begin
                     r_busErr <= 1'b1;
                  end
                  r_timer <= '0;
                  r_state <= IDLE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ram_en    = r_ramEn;
   assign ram_we    = r_ramWe;
   assign ram_size  = r_ramSize;
   assign ram_addr  = r_ramAddr;
   assign ram_wdata = r_ramWdata;
   assign if_rdata  = r_ifRdata;
   assign if_ready  = r_ifReady;
   assign mem_rdata = r_memRdata;
   assign mem_ready = r_memReady;
   assign bus_err   = r_busErr;

   // Stalls are combinational so the hazard unit sees them the same cycle.
   assign stall_if  = if_req & ~r_ifReady;
   assign stall_mem = mem_req & ~r_memReady;

`ifdef ARB_PERF_CNT_EN
   logic w_conflict;

   assign w_conflict = w_isIdle & w_ifElig & w_memElig;

   arb_perf_counters u_perf (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_grantIf   (w_grantIf),
      .i_grantMem  (w_grantMem),
      .i_conflict  (w_conflict),
      .o_ifGrants  (perf_if_grants),
      .o_memGrants (perf_mem_grants),
      .o_conflicts (perf_conflicts)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural memory with per-access
// latency answers the arbiter, a scoreboard holds the read data each port
// should receive, and a table of single accesses is followed by hand-built
// collision, starvation, timeout and reset sequences.
module tb_mem_port_arbiter;
   import arb_pkg::*;

   localparam int MAX_STARVE = 3;
   localparam int TIMEOUT    = 16;
   localparam int AW         = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [31:0]   if_rdata;
   logic          if_ready;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [1:0]    mem_size = 2'd0;
   logic [AW-1:0] mem_addr = '0;
   logic [31:0]   mem_wdata = '0;
   logic [31:0]   mem_rdata;
   logic          mem_ready;
   logic          ram_en;
   logic          ram_we;
   logic [1:0]    ram_size;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic          ram_valid;
   logic          stall_if;
   logic          stall_mem;
   logic          bus_err;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   perf_if_grants;
   logic [31:0]   perf_mem_grants;
   logic [31:0]   perf_conflicts;
`endif

   mem_port_arbiter #(
      .MAX_STARVE (MAX_STARVE),
      .TIMEOUT    (TIMEOUT),
      .AW         (AW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_size  (mem_size),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_size  (ram_size),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_valid (ram_valid),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .bus_err   (bus_err)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_if_grants  (perf_if_grants),
      .perf_mem_grants (perf_mem_grants),
      .perf_conflicts  (perf_conflicts)
`endif
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int nCompared = 0;
   int nMismatch = 0;

   logic [31:0] ifExp[$];
   logic [31:0] memExp[$];

   logic [31:0] memArr [0:255];
   int          memLat = 1;
   bit          respEnable = 1'b1;
   bit          injectStray = 1'b0;

   typedef struct {
      bit          isMem;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs[11];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatch++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Behavioural memory: sees ram_en, waits memLat cycles, performs the
   // access and acks with a one-cycle ram_valid. Reads return the
   // addressed lane zero-extended to 32 bits.
   initial begin : memModel
      logic [31:0] a;
      logic [31:0] wd;
      logic        we;
      logic [1:0]  sz;
      int          idx;
      int          lane;
      int          lat;
      ram_valid = 1'b0;
      ram_rdata = '0;
      forever begin
         @(negedge clk);
         ram_valid = 1'b0;
         if (injectStray) begin
            injectStray = 1'b0;
            ram_rdata = 32'hBAD0BAD0;
            ram_valid = 1'b1;
         end else if (ram_en && respEnable && reset_n) begin
            a = ram_addr; wd = ram_wdata; we = ram_we; sz = ram_size; lat = memLat;
            idx = int'(a[9:2]);
            lane = int'(a[1:0]);
            repeat (lat) @(negedge clk);
            if (we) begin
               case (sz)
                  SZ_BYTE: memArr[idx][8*lane +: 8] = wd[7:0];
                  SZ_HALF: memArr[idx][16*(lane/2) +: 16] = wd[15:0];
                  default: memArr[idx] = wd;
               endcase
               ram_rdata = 32'h0BADF00D;
            end else begin
               case (sz)
                  SZ_BYTE: ram_rdata = {24'd0, memArr[idx][8*lane +: 8]};
                  SZ_HALF: ram_rdata = {16'd0, memArr[idx][16*(lane/2) +: 16]};
                  default: ram_rdata = memArr[idx];
               endcase
            end
            ram_valid = 1'b1;
         end
      end
   end

   // Scoreboard: each ready pulse must match the oldest expected value.
   initial begin : monitor
      forever begin
         @(posedge clk);
         #2;
         if (if_ready) begin
            if (ifExp.size() == 0) checkOutput("if_unexpected_ready", {31'd0, if_ready}, 32'd0);
            else checkOutput("if_rdata", if_rdata, ifExp.pop_front());
         end
         if (mem_ready) begin
            if (memExp.size() == 0) checkOutput("mem_unexpected_ready", {31'd0, mem_ready}, 32'd0);
            else checkOutput("mem_rdata", mem_rdata, memExp.pop_front());
         end
      end
   end

   // Watchdog so a hung handshake still ends the run.
   initial begin : watchdog
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // One isolated access: checks request-to-ready latency, a single
   // ram_en pulse with the right attributes, and the stall line.
   task automatic applyStimulus(input vec_t v, input string tag);
      int          cyc = 0;
      int          enCount = 0;
      bit          done = 1'b0;
      bit          stallOk = 1'b1;
      logic [31:0] seenAddr = '0;
      logic [31:0] seenWdata = '0;
      logic        seenWe = 1'b0;
      logic [1:0]  seenSize = 2'd0;
      memLat = v.lat;
      @(posedge clk); #1;
      if (v.isMem) begin
         mem_we = v.we; mem_size = v.size; mem_addr = v.addr; mem_wdata = v.wdata;
         memExp.push_back(v.expRdata);
         mem_req = 1'b1;
      end else begin
         if_addr = v.addr;
         ifExp.push_back(v.expRdata);
         if_req = 1'b1;
      end
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (ram_en) begin
            enCount++;
            seenAddr = ram_addr; seenWe = ram_we; seenSize = ram_size; seenWdata = ram_wdata;
         end
         if (v.isMem ? mem_ready : if_ready) begin
            done = 1'b1;
         end else if (!(v.isMem ? stall_mem : stall_if)) begin
            stallOk = 1'b0;
         end
      end
      mem_req = 1'b0;
      if_req = 1'b0;
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(2 + v.lat));
      checkOutput({tag, "_ram_en_count"}, 32'(enCount), 32'd1);
      checkOutput({tag, "_ram_addr"}, seenAddr, v.addr);
      checkOutput({tag, "_ram_we"}, {31'd0, seenWe}, {31'd0, v.isMem & v.we});
      checkOutput({tag, "_ram_size"}, {30'd0, seenSize}, {30'd0, v.isMem ? v.size : SZ_WORD});
      if (v.isMem && v.we) checkOutput({tag, "_ram_wdata"}, seenWdata, v.wdata);
      checkOutput({tag, "_stall"}, {31'd0, stallOk}, 32'd1);
   endtask

   initial begin : stimulus
      int          cyc;
      int          enIdx;
      int          memReadyCyc;
      int          secondCyc;
      logic [31:0] firstAddr;
      logic [31:0] secondAddr;
      bit          stallOk;
      bit          ifDone;
      bit          ifRose;
      int          memDone;
      int          arbSinceIf;
      int          ifGrantIdx;
      bit          noEn;

      for (int i = 0; i < 256; i++) memArr[i] = '0;
      memArr[0] = 32'h00700093;
      memArr[1] = 32'h00000013;

      vecs[0]  = '{1'b0, 1'b0, SZ_WORD, 32'h00, 32'h0,        1, 32'h00700093};
      vecs[1]  = '{1'b1, 1'b1, SZ_BYTE, 32'h00, 32'hAAAAAA07, 0, 32'h00000000};
      vecs[2]  = '{1'b1, 1'b0, SZ_BYTE, 32'h00, 32'h0,        2, 32'h00000007};
      vecs[3]  = '{1'b1, 1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, 3, 32'h00000000};
      vecs[4]  = '{1'b1, 1'b0, SZ_HALF, 32'h12, 32'h0,        0, 32'h0000DEAD};
      vecs[5]  = '{1'b0, 1'b0, SZ_WORD, 32'h10, 32'h0,        2, 32'hDEADBEEF};
      vecs[6]  = '{1'b1, 1'b1, SZ_HALF, 32'h22, 32'h55551234, 1, 32'h00000000};
      vecs[7]  = '{1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0,        1, 32'h12340000};
      vecs[8]  = '{1'b0, 1'b0, SZ_WORD, 32'h04, 32'h0,        0, 32'h00000013};
      vecs[9]  = '{1'b0, 1'b0, SZ_WORD, 32'h00, 32'h0,        1, 32'h00700007};
      vecs[10] = '{1'b1, 1'b0, SZ_BYTE, 32'h13, 32'h0,        0, 32'h000000DE};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ram_ctrl", {28'd0, ram_en, ram_we, ram_size}, 32'd0);
      checkOutput("reset_ram_addr", ram_addr, 32'd0);
      checkOutput("reset_ram_wdata", ram_wdata, 32'd0);
      checkOutput("reset_rdata", if_rdata | mem_rdata, 32'd0);
      checkOutput("reset_flags", {29'd0, if_ready, mem_ready, bus_err}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Table of isolated accesses
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Collision: both ports ask in the same cycle
      memLat = 1;
      @(posedge clk); #1;
      mem_we = 1'b0; mem_size = SZ_WORD; mem_addr = 32'h10;
      if_addr = 32'h04;
      memExp.push_back(32'hDEADBEEF);
      ifExp.push_back(32'h00000013);
      mem_req = 1'b1; if_req = 1'b1;
      cyc = 0; enIdx = 0; memReadyCyc = -10; secondCyc = 0;
      firstAddr = '0; secondAddr = '0; stallOk = 1'b1; ifDone = 1'b0;
      while (!(ifDone && !mem_req) && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (ram_en) begin
            if (enIdx == 0) firstAddr = ram_addr;
            else if (enIdx == 1) begin secondAddr = ram_addr; secondCyc = cyc; end
            enIdx++;
         end
         if (mem_ready && mem_req) begin mem_req = 1'b0; memReadyCyc = cyc; end
         if (if_ready && if_req) begin if_req = 1'b0; ifDone = 1'b1; end
         else if (if_req && !stall_if) stallOk = 1'b0;
      end
      mem_req = 1'b0; if_req = 1'b0;
      checkOutput("collision_first_grant_addr", firstAddr, 32'h10);
      checkOutput("collision_second_grant_addr", secondAddr, 32'h04);
      checkOutput("collision_if_grant_cycle", 32'(secondCyc), 32'(memReadyCyc + 1));
      checkOutput("collision_grant_count", 32'(enIdx), 32'd2);
      checkOutput("collision_stall_if", {31'd0, stallOk}, 32'd1);

      // Starvation: MEM streams back-to-back, IF joins mid-stream
      repeat (2) @(posedge clk);
      #1;
      memLat = 1;
      mem_we = 1'b0; mem_size = SZ_WORD; mem_addr = 32'h10;
      memExp.push_back(32'hDEADBEEF);
      mem_req = 1'b1;
      ifRose = 1'b0; arbSinceIf = 0; ifGrantIdx = 0; memDone = 0; ifDone = 1'b0;
      stallOk = 1'b1;
      for (int c = 0; c < 200 && !(memDone == 5 && ifDone); c++) begin
         @(posedge clk); #1;
         if (ram_en && ifRose) begin
            arbSinceIf++;
            if (ram_addr == 32'h04 && ifGrantIdx == 0) ifGrantIdx = arbSinceIf;
         end
         if (mem_req && !mem_ready && !stall_mem) stallOk = 1'b0;
         if (mem_ready && mem_req) begin
            memDone++;
            if (memDone < 5) memExp.push_back(32'hDEADBEEF);
            else mem_req = 1'b0;
            if (memDone == 2) begin
               if_addr = 32'h04;
               ifExp.push_back(32'h00000013);
               if_req = 1'b1;
               ifRose = 1'b1;
            end
         end
         if (if_ready && if_req) begin if_req = 1'b0; ifDone = 1'b1; end
      end
      mem_req = 1'b0; if_req = 1'b0;
      checkOutput("starve_mem_accesses", 32'(memDone), 32'd5);
      checkOutput("starve_if_done", {31'd0, ifDone}, 32'd1);
      checkOutput("starve_if_grant_in_bound",
                  {31'd0, (ifGrantIdx >= 1) && (ifGrantIdx <= MAX_STARVE + 1)}, 32'd1);
      checkOutput("starve_stall_mem", {31'd0, stallOk}, 32'd1);

      // Timeout: memory never answers
      repeat (2) @(posedge clk);
      respEnable = 1'b0;
      vecs[0] = '{1'b1, 1'b0, SZ_WORD, 32'h30, 32'h0, TIMEOUT - 1, 32'h00000000};
      applyStimulus(vecs[0], "timeout");
      checkOutput("timeout_bus_err", {31'd0, bus_err}, 32'd1);
      respEnable = 1'b1;
      injectStray = 1'b1;
      noEn = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (ram_en) noEn = 1'b0;
      end
      checkOutput("stray_no_issue", {31'd0, noEn}, 32'd1);
      checkOutput("stray_bus_err_sticky", {31'd0, bus_err}, 32'd1);
      vecs[0] = '{1'b0, 1'b0, SZ_WORD, 32'h04, 32'h0, 1, 32'h00000013};
      applyStimulus(vecs[0], "post_timeout_fetch");
      checkOutput("post_timeout_bus_err", {31'd0, bus_err}, 32'd1);

      // Reset in the middle of a MEM access
      memLat = 6;
      @(posedge clk); #1;
      mem_we = 1'b0; mem_size = SZ_WORD; mem_addr = 32'h10;
      mem_req = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_ram_ctrl", {28'd0, ram_en, ram_we, ram_size}, 32'd0);
      checkOutput("midreset_ram_addr", ram_addr, 32'd0);
      checkOutput("midreset_rdata", if_rdata | mem_rdata, 32'd0);
      checkOutput("midreset_flags", {29'd0, if_ready, mem_ready, bus_err}, 32'd0);
      mem_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(posedge clk);
      vecs[0] = '{1'b0, 1'b0, SZ_WORD, 32'h00, 32'h0, 1, 32'h00700007};
      applyStimulus(vecs[0], "post_reset_fetch");
      repeat (4) @(posedge clk);
      checkOutput("scoreboard_if_drained", 32'(ifExp.size()), 32'd0);
      checkOutput("scoreboard_mem_drained", 32'(memExp.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
